// File: rtl/apb_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_if : command, response and APB signal bundle for apb_master
// Rev 1.0
// ----------------------------------------------------------------------------
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master : single-outstanding APB requester with wait-state timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         pclk,
  input  logic         rst_n,
  apb_master_if.master bus
);

  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit               TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q,  state_d;
  logic [ADDR_W-1:0] paddr_q,  paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic cmd_accept;

  assign cmd_accept = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          state_d  = SETUP;
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
          cnt_d    = '0;
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        // pready is tested first so a completion on the timeout cycle wins
        if (bus.pready) begin
          state_d  = RESP;
          rdata_d  = pwrite_q ? '0 : bus.prdata;
          err_d    = bus.pslverr;
          paddr_d  = '0;
          pwrite_d = 1'b0;
          pwdata_d = '0;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (TO_EN && (cnt_q == CNT_LAST)) begin
            state_d  = RESP;
            rdata_d  = '0;
            err_d    = 1'b1;
            paddr_d  = '0;
            pwrite_d = 1'b0;
            pwdata_d = '0;
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus strobes decode straight from the state so async reset drops them at once
  assign bus.cmd_ready = rst_n && (state_q == IDLE);
  assign bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_apb_master : scoreboard-based bench for apb_master (TIMEOUT=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_apb_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic pclk = 1'b0;
  logic rst_n;
  always #5 pclk = ~pclk;

  apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;
  exp_t sb[$];

  // Slave model: pready after s_waits stalled ACCESS cycles, never when hung
  int                s_waits = 0;
  logic              s_hang  = 1'b0;
  logic [DATA_W-1:0] s_rdata = '0;
  logic              s_err   = 1'b0;
  int                acc_cnt;

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign bus.pready  = bus.psel && bus.penable && !s_hang && (acc_cnt >= s_waits);
  assign bus.prdata  = s_rdata;
  assign bus.pslverr = s_err;

  // Bus-rule monitor
  int                psel_n = 0, pen_n = 0, viol = 0;
  logic              prev_setup = 1'b0, prev_psel = 1'b0;
  logic [ADDR_W-1:0] prev_addr  = '0;
  logic [DATA_W-1:0] prev_wdata = '0;

  always @(negedge pclk) begin
    psel_n <= psel_n + (bus.psel ? 1 : 0);
    pen_n  <= pen_n + (bus.penable ? 1 : 0);
    if ((bus.penable && !bus.psel) ||
        (rst_n && prev_setup && !(bus.psel && bus.penable)) ||
        (bus.psel && prev_psel && (bus.paddr !== prev_addr || bus.pwdata !== prev_wdata)))
      viol <= viol + 1;
    prev_setup <= bus.psel && !bus.penable;
    prev_psel  <= bus.psel;
    prev_addr  <= bus.paddr;
    prev_wdata <= bus.pwdata;
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
  endtask

  task automatic wait_rsp(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      step();
      n++;
      if (bus.rsp_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.cmd_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.cmd_ready});
    end
    checks++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want all 0", bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    int n; bit ok; int p0, e0; exp_t e;
    s_waits = 0; s_hang = 1'b0; s_err = 1'b0; s_rdata = 32'hA5A5_A5A5;
    bus.rsp_ready = 1'b1;
    p0 = psel_n; e0 = pen_n;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.cmd_ready} !== 4'b1010 ||
        bus.paddr !== 32'h10 || bus.pwdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_setup: sel/en/wr/rdy=%b addr=%h wdata=%h want 1010 00000010 deadbeef",
               {bus.psel, bus.penable, bus.pwrite, bus.cmd_ready}, bus.paddr, bus.pwdata);
    end
    wait_rsp(20, n, ok);
    checks++;
    if (!ok || n != 2) begin
      failures++;
      $display("FAIL wr_latency: got ok=%0d n=%0d want ok=1 n=2", ok, n);
    end
    e = sb.pop_front();
    checks++;
    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || bus.psel !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp: rdata=%h err=%b psel=%b want %h %b 0", bus.rsp_rdata, bus.rsp_err, bus.psel, e.rdata, e.err);
    end
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || psel_n - p0 != 2 || pen_n - e0 != 1) begin
      failures++;
      $display("FAIL wr_done: rdy=%b rv=%b psel_cyc=%0d pen_cyc=%0d want 1 0 2 1",
               bus.cmd_ready, bus.rsp_valid, psel_n - p0, pen_n - e0);
    end
  endtask

  // Three stalls put pready on the cycle the counter reaches TIMEOUT-1
  task automatic test_read_wait();
    int n; bit ok; int e0; exp_t e;
    s_waits = 3; s_rdata = 32'h0000_0020; s_err = 1'b0;
    e0 = pen_n;
    sb.push_back('{rdata: 32'h20, err: 1'b0});
    issue(1'b0, 32'h20, 32'hFFFF_FFFF);
    checks++;
    if (bus.pwrite !== 1'b0 || bus.pwdata !== 32'h0 || bus.paddr !== 32'h20) begin
      failures++;
      $display("FAIL rd_setup: wr=%b wdata=%h addr=%h want 0 00000000 00000020", bus.pwrite, bus.pwdata, bus.paddr);
    end
    wait_rsp(20, n, ok);
    checks++;
    if (!ok || n != 5 || pen_n - e0 != 4) begin
      failures++;
      $display("FAIL rd_wait_latency: ok=%0d n=%0d pen_cyc=%0d want 1 5 4", ok, n, pen_n - e0);
    end
    e = sb.pop_front();
    checks++;
    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL rd_wait_rsp: rdata=%h err=%b want %h %b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    step();
  endtask

  task automatic test_slverr();
    int n; bit ok; exp_t e;
    s_waits = 1; s_rdata = 32'h1357_9BDF; s_err = 1'b1;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b1, 32'h30, 32'h0BAD_F00D);
    wait_rsp(20, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n != 3 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL slverr_rsp: ok=%0d n=%0d rdata=%h err=%b want 1 3 %h %b", ok, n, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    step();
    s_err = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL slverr_idle: rdy=%b err=%b want 1 0", bus.cmd_ready, bus.rsp_err);
    end
  endtask

  task automatic test_timeout();
    int n; bit ok; int e0; exp_t e;
    s_hang = 1'b1; s_rdata = 32'hFEED_FACE;
    e0 = pen_n;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b0, 32'h40, 32'h0);
    wait_rsp(20, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n != 5 || pen_n - e0 != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_latency: ok=%0d n=%0d pen_cyc=%0d want 1 5 %0d", ok, n, pen_n - e0, TIMEOUT);
    end
    checks++;
    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      failures++;
      $display("FAIL timeout_rsp: rdata=%h err=%b sel=%b en=%b want %h %b 0 0",
               bus.rsp_rdata, bus.rsp_err, bus.psel, bus.penable, e.rdata, e.err);
    end
    step();
    s_hang = 1'b0; s_waits = 0; s_rdata = 32'hCAFE_0044;
    sb.push_back('{rdata: 32'hCAFE_0044, err: 1'b0});
    issue(1'b0, 32'h44, 32'h0);
    wait_rsp(20, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n != 2 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL timeout_recover: ok=%0d n=%0d rdata=%h err=%b want 1 2 %h %b", ok, n, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    step();
  endtask

  task automatic test_backpressure();
    int n; bit ok; exp_t e;
    s_waits = 0; s_rdata = 32'h5555_AAAA;
    bus.rsp_ready = 1'b0;
    sb.push_back('{rdata: 32'h5555_AAAA, err: 1'b0});
    issue(1'b0, 32'h50, 32'h0);
    wait_rsp(20, n, ok);
    s_rdata = 32'h0;
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: rv=%b rdata=%h rdy=%b sel=%b want 1 %h 0 0",
                 k, bus.rsp_valid, bus.rsp_rdata, bus.cmd_ready, bus.psel, e.rdata);
      end
      if (k < 4) step();
    end
    step();
    bus.rsp_ready = 1'b1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata) begin
      failures++;
      $display("FAIL bp_final: rv=%b rdata=%h want 1 %h", bus.rsp_valid, bus.rsp_rdata, e.rdata);
    end
    step();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: rdy=%b rv=%b want 1 0", bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    int n; bit ok; exp_t e; logic seen;
    s_hang = 1'b1;
    issue(1'b1, 32'h66, 32'h0000_1234);
    step();
    checks++;
    if ({bus.psel, bus.penable} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_pre: sel/en=%b want 11", {bus.psel, bus.penable});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b0 || bus.paddr !== '0 || bus.pwdata !== '0) begin
      failures++;
      $display("FAIL rst_mid_async: sel/en/rdy=%b addr=%h wdata=%h want 000 0 0",
               {bus.psel, bus.penable, bus.cmd_ready}, bus.paddr, bus.pwdata);
    end
    step();
    step();
    s_hang = 1'b0;
    rst_n  = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | bus.rsp_valid;
    end
    checks++;
    if (seen !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_discard: rsp_seen=%b rdy=%b want 0 1", seen, bus.cmd_ready);
    end
    s_rdata = 32'h0000_0077;
    sb.push_back('{rdata: 32'h77, err: 1'b0});
    issue(1'b0, 32'h70, 32'h0);
    checks++;
    if ({bus.psel, bus.penable} !== 2'b10 || bus.paddr !== 32'h70) begin
      failures++;
      $display("FAIL rst_mid_next_setup: sel/en=%b addr=%h want 10 00000070", {bus.psel, bus.penable}, bus.paddr);
    end
    wait_rsp(20, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n != 2 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      failures++;
      $display("FAIL rst_mid_next_rsp: ok=%0d n=%0d rdata=%h err=%b want 1 2 %h %b", ok, n, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    step();
  endtask

  task automatic test_bus_rules();
    checks++;
    if (viol != 0 || sb.size() != 0) begin
      failures++;
      $display("FAIL bus_rules: violations=%0d pending=%0d want 0 0", viol, sb.size());
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
